// File: rtl/pool_scheduler_if.sv
// pool_scheduler_if
//   Bundles every non-clock/reset signal of the pool scheduler:
//     - the layer-controller handshake: start, num_ch, busy, done, err
//     - the input-buffer read port:     rd_en, rd_addr, rd_data
//     - the pooler hookup:              pool_ce, pool_rst, pool_din, pool_dout, pool_valid
//     - the output-buffer write port:   wr_en, wr_addr, wr_data, wr_ready
//   The master modport is the scheduler's view. The slave modport is the view of the
//   surrounding controller, RAMs and pooler.
interface pool_scheduler_if #(
  parameter int N  = 16,
  parameter int AW = 12
);
  logic          start;
  logic [7:0]    num_ch;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic          pool_ce;
  logic          pool_rst;
  logic [N-1:0]  pool_din;
  logic [N-1:0]  pool_dout;
  logic          pool_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          wr_ready;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start, num_ch, rd_data, pool_dout, pool_valid, wr_ready,
    output rd_en, rd_addr, pool_ce, pool_rst, pool_din,
           wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    output start, num_ch, rd_data, pool_dout, pool_valid, wr_ready,
    input  rd_en, rd_addr, pool_ce, pool_rst, pool_din,
           wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/pool_scheduler.sv
// pool_scheduler
//   Drives a single pooling engine across every channel of a feature map.
//   For each channel it does the following:
//     - reads M*M words from the input buffer;
//     - streams them into the pooler under pool_ce;
//     - captures the (M/P)^2 pooled results into a 4-entry skid FIFO;
//     - writes those results to the output buffer.
//   Ports:
//     clk        rising-edge clock
//     master_rst asynchronous active-low reset
//     bus        pool_scheduler_if.master, carrying the handshake, RAM and pooler signals
module pool_scheduler #(
  parameter int N   = 16,
  parameter int M   = 12,
  parameter int P   = 3,
  parameter int AW  = 12,
  parameter int TMO = 64
) (
  input  logic              clk,
  input  logic              master_rst,
  pool_scheduler_if.master  bus
);

  localparam int IPC = M * M;
  localparam int OPC = (M / P) * (M / P);
  localparam int ICW = $clog2(IPC + 1);
  localparam int OCW = $clog2(OPC + 1);
  localparam int TCW = $clog2(TMO + 1);
  localparam logic [ICW-1:0] IPC_C    = ICW'(IPC);
  localparam logic [OCW-1:0] OPC_C    = OCW'(OPC);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TMO - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_DRAIN, S_NEXT, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [7:0]     ch_q, nch_q;
  logic           clr_q;
  logic [ICW-1:0] in_cnt_q;
  logic [OCW-1:0] out_cnt_q;
  logic [TCW-1:0] tmo_q;
  logic [AW-1:0]  rd_addr_q, wr_addr_q;
  logic           rd_v_q, ce_q;
  logic [N-1:0]   din_q;
  logic           err_q;
  logic [N-1:0]   fifo_q [4];
  logic [1:0]     wp_q, rp_q;
  logic [2:0]     fcnt_q;

  logic start_acc_s, run_s, rd_en_s, cap_s, push_s, over_s, pop_s, drain_ok_s, flush_s;

  // Read gating leaves FIFO room for results still in the 2-deep read pipeline.
  assign start_acc_s = (state_q == S_IDLE) && bus.start;
  assign run_s       = (state_q == S_FEED) || (state_q == S_DRAIN) || (state_q == S_NEXT);
  assign rd_en_s     = (state_q == S_FEED) && (in_cnt_q < IPC_C) && (fcnt_q <= 3'd1);
  assign cap_s       = run_s && bus.pool_valid && ce_q;
  assign push_s      = cap_s && (out_cnt_q < OPC_C);
  assign over_s      = cap_s && (out_cnt_q >= OPC_C);
  assign pop_s       = (fcnt_q != 3'd0) && bus.wr_ready;
  assign drain_ok_s  = (out_cnt_q == OPC_C) && (fcnt_q == 3'd0);
  assign flush_s     = (state_q == S_DRAIN) && !drain_ok_s && !cap_s && (tmo_q == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc_s) state_d = S_CLR; else state_d = S_IDLE;
      S_CLR:   if (clr_q) state_d = S_FEED; else state_d = S_CLR;
      // Leave FEED only once the last read has left the rd_data stage.
      S_FEED:  if ((in_cnt_q == IPC_C) && !rd_v_q) state_d = S_DRAIN; else state_d = S_FEED;
      S_DRAIN: begin
        if (drain_ok_s)   state_d = S_NEXT;
        else if (flush_s) state_d = S_DONE;
        else              state_d = S_DRAIN;
      end
      S_NEXT:  if ((ch_q + 8'd1) == nch_q) state_d = S_DONE; else state_d = S_CLR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Layer/channel bookkeeping, address counters, read pipeline and error flag
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      ch_q      <= 8'd0;
      nch_q     <= 8'd0;
      clr_q     <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      tmo_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_v_q    <= 1'b0;
      ce_q      <= 1'b0;
      din_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_v_q <= rd_en_s;
      ce_q   <= rd_v_q;
      if (rd_v_q) din_q <= bus.rd_data;
      // Marks the second CLR cycle.
      clr_q  <= (state_q == S_CLR);

      if (start_acc_s) begin
        nch_q     <= (bus.num_ch == 8'd0) ? 8'd1 : bus.num_ch;
        ch_q      <= 8'd0;
        rd_addr_q <= '0;
        wr_addr_q <= '0;
        err_q     <= 1'b0;
      end else begin
        if (rd_en_s) rd_addr_q <= rd_addr_q + AW'(1);
        if (pop_s)   wr_addr_q <= wr_addr_q + AW'(1);
        if (over_s || flush_s) err_q <= 1'b1;
        if (state_q == S_NEXT) ch_q <= ch_q + 8'd1;
      end

      if (state_q == S_CLR) begin
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (rd_en_s) in_cnt_q  <= in_cnt_q + ICW'(1);
        if (push_s)  out_cnt_q <= out_cnt_q + OCW'(1);
      end

      // Timeout counts DRAIN cycles since the most recent capture.
      if ((state_q != S_DRAIN) || cap_s) tmo_q <= '0;
      else                               tmo_q <= tmo_q + TCW'(1);
    end
  end

  // Result FIFO: pushed by captures, popped by accepted writes, flushed on timeout
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      wp_q   <= 2'd0;
      rp_q   <= 2'd0;
      fcnt_q <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else if (flush_s) begin
      wp_q   <= 2'd0;
      rp_q   <= 2'd0;
      fcnt_q <= 3'd0;
    end else begin
      if (push_s) begin
        fifo_q[wp_q] <= bus.pool_dout;
        wp_q         <= wp_q + 2'd1;
      end
      if (pop_s) rp_q <= rp_q + 2'd1;
      case ({push_s, pop_s})
        2'b10:   fcnt_q <= fcnt_q + 3'd1;
        2'b01:   fcnt_q <= fcnt_q - 3'd1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  assign bus.rd_en    = rd_en_s;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.pool_ce  = ce_q;
  assign bus.pool_rst = run_s;
  assign bus.pool_din = din_q;
  assign bus.wr_en    = pop_s;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = fifo_q[rp_q];
  assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_pool_scheduler.sv
// tb_pool_scheduler
//   Bench for pool_scheduler (M=12, P=3). It surrounds the scheduler with the following:
//     - an input RAM holding a known pattern;
//     - a max-pooling engine model;
//     - an output-RAM write logger.
//   Expected outputs come from a window-max computed directly on the pattern.
module tb_pool_scheduler;
  localparam int N   = 16;
  localparam int M   = 12;
  localparam int P   = 3;
  localparam int AW  = 12;
  localparam int TMO = 64;
  localparam int IPC = M * M;
  localparam int OPC = (M / P) * (M / P);

  logic clk = 1'b0;
  logic master_rst;
  always #5 clk = ~clk;

  pool_scheduler_if #(.N(N), .AW(AW)) bus ();
  pool_scheduler #(.N(N), .M(M), .P(P), .AW(AW), .TMO(TMO)) dut (
    .clk(clk), .master_rst(master_rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] mem_val(input int a);
    return N'(a * 3 + 5);
  endfunction

  // Reference result g of a layer: max over its PxP window in channel g/OPC.
  function automatic logic [N-1:0] exp_out(input int g);
    int ch, w, br, bc, a;
    logic [N-1:0] m, v;
    ch = g / OPC; w = g % OPC; br = w / (M / P); bc = w % (M / P);
    m = '0;
    for (int i = 0; i < P; i++)
      for (int j = 0; j < P; j++) begin
        a = ch * IPC + (br * P + i) * M + bc * P + j;
        v = mem_val(a);
        if (v > m) m = v;
      end
    return m;
  endfunction

  // Input RAM, 1-cycle read latency
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem_val(int'(bus.rd_addr));

  // Max-pooling engine model; result is presented with the input that completes a window
  int pk = 0;
  logic withhold;
  logic [N-1:0] acc [0:3];
  int prow, pcol, pw;
  logic [N-1:0] win_max;
  assign prow = pk / M;
  assign pcol = pk % M;
  assign pw   = pcol / P;
  assign win_max = (acc[pw] > bus.pool_din) ? acc[pw] : bus.pool_din;
  assign bus.pool_dout  = win_max;
  assign bus.pool_valid = bus.pool_ce && ((prow % P) == P - 1) && ((pcol % P) == P - 1)
                          && !(withhold && pk == IPC - 1);
  always @(posedge clk) begin
    if (!bus.pool_rst) pk <= 0;
    else if (bus.pool_ce) begin
      pk <= pk + 1;
      acc[pw] <= ((prow % P) == 0 && (pcol % P) == 0) ? bus.pool_din : win_max;
    end
  end

  // Event counters for the current layer
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int layer_reads, layer_writes, layer_dones, layer_blo, occ, last_cap, done_cyc;
  logic [N-1:0] wr_log [0:63];
  logic cap;
  assign cap = bus.pool_rst && bus.pool_valid && bus.pool_ce;

  always @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      layer_reads <= 0; layer_writes <= 0; layer_dones <= 0; layer_blo <= 0; occ <= 0;
    end else begin
      if (bus.start && !bus.busy) begin
        layer_reads <= 0; layer_writes <= 0; layer_dones <= 0; layer_blo <= 0;
      end else begin
        if (bus.rd_en) layer_reads <= layer_reads + 1;
        if (bus.wr_en) begin
          layer_writes <= layer_writes + 1;
          wr_log[bus.wr_addr[5:0]] <= bus.wr_data;
        end
        if (bus.done) begin
          layer_dones <= layer_dones + 1;
          done_cyc <= cyc;
        end
        if (bus.busy && !bus.pool_rst) layer_blo <= layer_blo + 1;
      end
      occ <= occ + (cap ? 1 : 0) - (bus.wr_en ? 1 : 0);
      if (cap) last_cap <= cyc;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (master_rst) begin
      if (bus.rd_en) begin
        chk("rd_addr", bus.rd_addr, layer_reads % 4096);
        chk("rd_gate_fifo_le1", (occ <= 1) ? 1 : 0, 1);
      end
      if (bus.wr_en) begin
        chk("wr_addr", bus.wr_addr, layer_writes % 4096);
        chk("wr_data", bus.wr_data, exp_out(layer_writes));
      end
      if (!bus.busy) chk("idle_pool_rst", bus.pool_rst, 0);
    end
  end

  task automatic start_layer(input logic [7:0] nch);
    @(negedge clk);
    bus.start = 1'b1; bus.num_ch = nch;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (layer_dones == 0 && t < 3000) begin @(negedge clk); t++; end
    chk("done_seen", (layer_dones != 0) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_reads(input int n);
    int t = 0;
    while (layer_reads < n && t < 2000) begin @(negedge clk); t++; end
    chk("reads_reached", (layer_reads >= n) ? 1 : 0, 1);
  endtask

  initial begin
    int r0, w0, gap;
    master_rst = 1'b0; bus.start = 1'b0; bus.num_ch = 8'd0; bus.wr_ready = 1'b1; withhold = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);        chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);          chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_wr_en", bus.wr_en, 0);      chk("rst_pool_rst", bus.pool_rst, 0);
    chk("rst_pool_ce", bus.pool_ce, 0);  chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);  chk("rst_wr_data", bus.wr_data, 0);
    master_rst = 1'b1;
    repeat (2) @(negedge clk);

    // One channel
    start_layer(8'd1); wait_done();
    chk("c1_reads", layer_reads, 144);  chk("c1_writes", layer_writes, 16);
    chk("c1_dones", layer_dones, 1);    chk("c1_rst_lo", layer_blo, 2);
    chk("c1_err", bus.err, 0);          chk("c1_out0", wr_log[0], 83);
    chk("c1_out15", wr_log[15], 434);   chk("c1_pool_rst_after", bus.pool_rst, 0);

    // Three channels, contiguous addresses
    start_layer(8'd3); wait_done();
    chk("c3_reads", layer_reads, 432);  chk("c3_writes", layer_writes, 48);
    chk("c3_dones", layer_dones, 1);    chk("c3_rst_lo", layer_blo, 6);
    chk("c3_out16", wr_log[16], 515);   chk("c3_out47", wr_log[47], 1298);
    chk("c3_pool_rst_after", bus.pool_rst, 0);

    // Output back-pressure mid-FEED
    start_layer(8'd1); wait_reads(30);
    bus.wr_ready = 1'b0; r0 = layer_reads; w0 = layer_writes;
    repeat (50) @(negedge clk);
    chk("stall_reads_bounded", ((layer_reads - r0) < 10) ? 1 : 0, 1);
    chk("stall_no_writes", layer_writes - w0, 0);
    bus.wr_ready = 1'b1;
    wait_done();
    chk("stall_reads", layer_reads, 144); chk("stall_writes", layer_writes, 16);
    chk("stall_err", bus.err, 0);

    // Missing last result -> drain timeout
    withhold = 1'b1;
    start_layer(8'd1); wait_done();
    gap = done_cyc - last_cap;
    chk("tmo_err", bus.err, 1);          chk("tmo_writes", layer_writes, 15);
    chk("tmo_dones", layer_dones, 1);
    chk("tmo_gap_64_72", (gap >= 64 && gap <= 72) ? 1 : 0, 1);
    withhold = 1'b0;
    repeat (10) @(negedge clk);
    chk("tmo_err_sticky", bus.err, 1);   chk("tmo_flushed", layer_writes, 15);
    start_layer(8'd1);
    repeat (2) @(negedge clk);
    chk("err_cleared", bus.err, 0);      chk("busy_after_start", bus.busy, 1);
    wait_done();
    chk("rerun_reads", layer_reads, 144); chk("rerun_writes", layer_writes, 16);

    // num_ch=0 is one channel; start while busy is ignored
    start_layer(8'd0); wait_reads(50);
    start_layer(8'd5); wait_done();
    chk("ch0_reads", layer_reads, 144);  chk("ch0_writes", layer_writes, 16);
    chk("ch0_dones", layer_dones, 1);    chk("ch0_rst_lo", layer_blo, 2);

    // Asynchronous reset mid-FEED
    start_layer(8'd1); wait_reads(40);
    #3 master_rst = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);        chk("arst_rd_en", bus.rd_en, 0);
    chk("arst_pool_rst", bus.pool_rst, 0); chk("arst_pool_ce", bus.pool_ce, 0);
    chk("arst_rd_addr", bus.rd_addr, 0);  chk("arst_wr_addr", bus.wr_addr, 0);
    chk("arst_wr_en", bus.wr_en, 0);
    @(negedge clk) master_rst = 1'b1;
    repeat (2) @(negedge clk);
    start_layer(8'd1); wait_done();
    chk("post_rst_reads", layer_reads, 144); chk("post_rst_writes", layer_writes, 16);
    chk("post_rst_out0", wr_log[0], 83);     chk("post_rst_err", bus.err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
